load_return_unit: RTL and testbench

- Read-side counterpart of the EX-stage store path.
- Captures a load issued in EX and aligns the synchronous-memory read data arriving in MWB. Sources are DMEM, BIOS or IO.
- Sign- or zero-extends the result and delivers it to writeback/forwarding.
- Owns the memory-mapped cycle and retired-instruction counters that the IO region reads back.

---
 rtl/load_return_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_load_return_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_return_unit.sv
// -----------------------------------------------------------------------------
// load_return_unit
//
// Read-side counterpart of the EX-stage store path. A load issued in EX is
// captured into an EX->MWB register. During MWB the synchronous read data
// (DMEM, BIOS or IO) is selected, aligned to the addressed byte/half and
// sign- or zero-extended for writeback and forwarding. The block also owns
// the memory-mapped cycle and retired-instruction counters that the IO region
// reads back.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   ld_valid_ex         EX holds a (non-bubble) load
//   ld_funct3_ex        load funct3 (LB/LH/LW/LBU/LHU, others return the word)
//   ld_addr_ex          load effective address in EX
//   st_valid_ex         EX holds a store
//   st_addr_ex          store effective address in EX (counter-clear target)
//   inst_retire         a non-bubble instruction leaves MWB this cycle
//   dmem_rdata          DMEM read data, one cycle after the address
//   bios_rdata          BIOS read data, one cycle after the address
//   io_rdata            other IO register read data, one cycle after the address
//   ld_valid_mwb        registered load valid in MWB
//   ld_data_mwb         aligned, extended load result (0 when not valid)
//   ld_err_mwb          misaligned-load flag (0 when not valid)
//   cycle_cnt           current cycle counter, zero-extended to 32 bits
//   inst_cnt            current retired-instruction counter, zero-extended
//
// Build option:
//   MISALIGN_TRAP_EN    when defined, misaligned LH/LHU/LW loads raise
//                       ld_err_mwb and return 0. When undefined, ld_err_mwb is
//                       tied low and the low address bits below the access
//                       size are ignored (accesses are force-aligned).
//
// Counter snapshots taken for an IO counter read hold the counter value as it
// stands after the load's EX edge, i.e. the value visible while the load is in
// MWB. A counter read issued right after a clearing store therefore returns 1.
// -----------------------------------------------------------------------------
module load_return_unit #(
  parameter int          CTR_WIDTH       = 32,
  parameter logic [31:0] IO_CYC_ADDR     = 32'h8000_0010,
  parameter logic [31:0] IO_INST_ADDR    = 32'h8000_0014,
  parameter logic [31:0] IO_CTR_RST_ADDR = 32'h8000_0018
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid_ex,
  input  logic [2:0]  ld_funct3_ex,
  input  logic [31:0] ld_addr_ex,
  input  logic        st_valid_ex,
  input  logic [31:0] st_addr_ex,
  input  logic        inst_retire,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] bios_rdata,
  input  logic [31:0] io_rdata,
  output logic        ld_valid_mwb,
  output logic [31:0] ld_data_mwb,
  output logic        ld_err_mwb,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt
);

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_DMEM = 2'd1,
    REG_BIOS = 2'd2,
    REG_IO   = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    IO_OTHER = 2'd0,
    IO_CYC   = 2'd1,
    IO_INST  = 2'd2
  } io_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // ---------------------------------------------------------------------------
  // EX -> MWB register fields and counters
  // ---------------------------------------------------------------------------
  logic                 ld_valid_q, ld_valid_d;
  logic [2:0]           funct3_q,   funct3_d;
  logic [1:0]           off_q,      off_d;
  region_e              region_q,   region_d;
  io_sel_e              io_sel_q,   io_sel_d;
  logic [CTR_WIDTH-1:0] cyc_snap_q, cyc_snap_d;
  logic [CTR_WIDTH-1:0] inst_snap_q, inst_snap_d;
  logic [CTR_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CTR_WIDTH-1:0] inst_cnt_q,  inst_cnt_d;
  logic                 ctr_clear;

  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ld_valid_d = ld_valid_ex;
    funct3_d   = ld_funct3_ex;
    off_d      = ld_addr_ex[1:0];

    region_d = REG_NONE;
    casez (ld_addr_ex[31:28])
      4'b00?1: region_d = REG_DMEM;
      4'b0100: region_d = REG_BIOS;
      4'b1000: region_d = REG_IO;
      default: region_d = REG_NONE;
    endcase

    io_sel_d = IO_OTHER;
    if (ld_addr_ex == IO_CYC_ADDR)       io_sel_d = IO_CYC;
    else if (ld_addr_ex == IO_INST_ADDR) io_sel_d = IO_INST;

    // A clearing store overrides the increment of the same cycle.
    ctr_clear   = st_valid_ex && (st_addr_ex == IO_CTR_RST_ADDR);
    cycle_cnt_d = cycle_cnt_q + CTR_WIDTH'(1);
    inst_cnt_d  = inst_cnt_q + (inst_retire ? CTR_WIDTH'(1) : CTR_WIDTH'(0));
    if (ctr_clear) begin
      cycle_cnt_d = '0;
      inst_cnt_d  = '0;
    end

    cyc_snap_d  = cycle_cnt_d;
    inst_snap_d = inst_cnt_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid_q  <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      region_q    <= REG_NONE;
      io_sel_q    <= IO_OTHER;
      cyc_snap_q  <= '0;
      inst_snap_q <= '0;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      ld_valid_q  <= ld_valid_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      region_q    <= region_d;
      io_sel_q    <= io_sel_d;
      cyc_snap_q  <= cyc_snap_d;
      inst_snap_q <= inst_snap_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  assign cycle_cnt = 32'(cycle_cnt_q);
  assign inst_cnt  = 32'(inst_cnt_q);

  // ---------------------------------------------------------------------------
  // Misalignment flag
  // ---------------------------------------------------------------------------
  logic misalign_q;

`ifdef MISALIGN_TRAP_EN
  logic misalign_d;

  always_comb begin
    misalign_d = 1'b0;
    case (ld_funct3_ex)
      F3_LH, F3_LHU: misalign_d = ld_addr_ex[0];
      F3_LW:         misalign_d = (ld_addr_ex[1:0] != 2'b00);
      default:       misalign_d = 1'b0;
    endcase
    misalign_d = misalign_d && ld_valid_ex;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign misalign_q = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // MWB: source select, alignment, extension
  // ---------------------------------------------------------------------------
  logic [31:0] src_word;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_val;

  always_comb begin
    src_word = '0;
    case (region_q)
      REG_DMEM: src_word = dmem_rdata;
      REG_BIOS: src_word = bios_rdata;
      REG_IO: begin
        case (io_sel_q)
          IO_CYC:  src_word = 32'(cyc_snap_q);
          IO_INST: src_word = 32'(inst_snap_q);
          default: src_word = io_rdata;
        endcase
      end
      default:  src_word = '0;
    endcase

    // Halves use only addr[1]; addr[0] is either ignored or trapped.
    byte_sh = src_word >> {off_q, 3'b000};
    half_sh = src_word >> {off_q[1], 4'b0000};

    load_val = src_word;
    case (funct3_q)
      F3_LB:   load_val = {{24{byte_sh[7]}},  byte_sh[7:0]};
      F3_LH:   load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_LBU:  load_val = {24'h0, byte_sh[7:0]};
      F3_LHU:  load_val = {16'h0, half_sh[15:0]};
      default: load_val = src_word;  // LW and undefined encodings
    endcase

    ld_data_mwb = '0;
    if (ld_valid_q && !misalign_q) ld_data_mwb = load_val;
  end

  assign ld_valid_mwb = ld_valid_q;
  assign ld_err_mwb   = ld_valid_q & misalign_q;

endmodule

// File: tb/tb_load_return_unit.sv
// -----------------------------------------------------------------------------
// Testbench for load_return_unit. Randomized and directed stimulus is checked
// against a behavioural model built from plain arithmetic on the addressed
// word and integer counters. A second instance with a 4-bit counter width
// exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_load_return_unit;

  localparam logic [31:0] CYC_A  = 32'h8000_0010;
  localparam logic [31:0] INST_A = 32'h8000_0014;
  localparam logic [31:0] RST_A  = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid_ex;
  logic [2:0]  ld_funct3_ex;
  logic [31:0] ld_addr_ex;
  logic        st_valid_ex;
  logic [31:0] st_addr_ex;
  logic        inst_retire;
  logic [31:0] dmem_rdata, bios_rdata, io_rdata;
  logic        ld_valid_mwb, ld_err_mwb;
  logic [31:0] ld_data_mwb, cycle_cnt, inst_cnt;
  logic        s_ld_valid, s_ld_err;
  logic [31:0] s_ld_data, s_cycle_cnt, s_inst_cnt;

  always #5 clk = ~clk;

  load_return_unit dut (
    .clk(clk), .rst(rst),
    .ld_valid_ex(ld_valid_ex), .ld_funct3_ex(ld_funct3_ex), .ld_addr_ex(ld_addr_ex),
    .st_valid_ex(st_valid_ex), .st_addr_ex(st_addr_ex), .inst_retire(inst_retire),
    .dmem_rdata(dmem_rdata), .bios_rdata(bios_rdata), .io_rdata(io_rdata),
    .ld_valid_mwb(ld_valid_mwb), .ld_data_mwb(ld_data_mwb), .ld_err_mwb(ld_err_mwb),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  load_return_unit #(.CTR_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst),
    .ld_valid_ex(ld_valid_ex), .ld_funct3_ex(ld_funct3_ex), .ld_addr_ex(ld_addr_ex),
    .st_valid_ex(st_valid_ex), .st_addr_ex(st_addr_ex), .inst_retire(inst_retire),
    .dmem_rdata(dmem_rdata), .bios_rdata(bios_rdata), .io_rdata(io_rdata),
    .ld_valid_mwb(s_ld_valid), .ld_data_mwb(s_ld_data), .ld_err_mwb(s_ld_err),
    .cycle_cnt(s_cycle_cnt), .inst_cnt(s_inst_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          v;
    logic [2:0]  f3;
    logic [31:0] addr;
    int unsigned sc;
    int unsigned si;
  } pend_t;

  pend_t       pend;
  int unsigned m_cyc, m_inst;

  function automatic logic [31:0] model_load(input pend_t p, output bit err);
    int unsigned w, b, h, bi, hi;
    int          v;
    bit          mis;
    logic [3:0]  top;
    err = 1'b0;
    if (!p.v) return 32'h0;
    top = p.addr[31:28];
    if (top == 4'h1 || top == 4'h3)  w = dmem_rdata;
    else if (top == 4'h4)            w = bios_rdata;
    else if (top == 4'h8) begin
      if (p.addr == CYC_A)           w = p.sc;
      else if (p.addr == INST_A)     w = p.si;
      else                           w = io_rdata;
    end else                         w = 0;
    bi  = p.addr % 4;
    hi  = (p.addr % 4) / 2;
    mis = ((p.f3 == 3'd1 || p.f3 == 3'd5) && (p.addr % 2 != 0)) ||
          (p.f3 == 3'd2 && (p.addr % 4 != 0));
`ifdef MISALIGN_TRAP_EN
    if (mis) begin
      err = 1'b1;
      return 32'h0;
    end
`else
    if (mis) err = 1'b0;
`endif
    b = (w / (1 << (8 * bi))) % 256;
    h = (w / (1 << (16 * hi))) % 65536;
    case (p.f3)
      3'd0: begin v = int'(b); if (v > 127)   v -= 256;   return 32'(v); end
      3'd1: begin v = int'(h); if (v > 32767) v -= 65536; return 32'(v); end
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  // One clock cycle: drive EX inputs and MWB read data, check MWB outputs
  // and counters before the edge, then advance the model across the edge.
  task automatic do_cycle(input bit lv, input logic [2:0] f3, input logic [31:0] la,
                          input bit sv, input logic [31:0] sa, input bit ret,
                          input logic [31:0] dm, input logic [31:0] bm,
                          input bit chk_c, input logic [31:0] cval);
    logic [31:0] exp_d;
    bit          exp_e;
    bit          clr;
    ld_valid_ex  = lv;
    ld_funct3_ex = f3;
    ld_addr_ex   = la;
    st_valid_ex  = sv;
    st_addr_ex   = sa;
    inst_retire  = ret;
    dmem_rdata   = dm;
    bios_rdata   = bm;
    io_rdata     = $urandom;
    @(negedge clk);
    exp_d = model_load(pend, exp_e);
    check("ld_valid", 32'(ld_valid_mwb), 32'(pend.v));
    check("ld_data", ld_data_mwb, exp_d);
    check("ld_err", 32'(ld_err_mwb), 32'(exp_e));
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("inst_cnt", inst_cnt, m_inst);
    check("small_cycle_cnt", s_cycle_cnt, m_cyc % 16);
    check("small_inst_cnt", s_inst_cnt, m_inst % 16);
    if (chk_c) check("directed_data", ld_data_mwb, cval);
    @(posedge clk);
    clr    = sv && (sa == RST_A);
    m_cyc  = clr ? 0 : m_cyc + 1;
    m_inst = clr ? 0 : m_inst + (ret ? 1 : 0);
    pend   = '{v: lv, f3: f3, addr: la, sc: m_cyc, si: m_inst};
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 8)
      0: return {4'h1, 28'($urandom)};
      1: return {4'h3, 28'($urandom)};
      2: return {4'h4, 28'($urandom)};
      3: return {4'h8, 28'($urandom)};
      4: return CYC_A;
      5: return INST_A;
      6: return 32'($urandom);
      default: return 32'h1000_0000 | 32'($urandom % 4);
    endcase
  endfunction

  task automatic rand_cycle(input bit ret, input bit allow_clr);
    int          kind;
    logic [31:0] sa;
    kind = $urandom % 10;
    sa   = (allow_clr && ($urandom % 4 == 0)) ? RST_A : 32'($urandom);
    if (kind < 6)
      do_cycle(1'b1, 3'($urandom), rand_addr(), 1'b0, 32'h0, ret, $urandom, $urandom, 1'b0, 32'h0);
    else if (kind < 8)
      do_cycle(1'b0, 3'($urandom), rand_addr(), 1'b1, sa, ret, $urandom, $urandom, 1'b0, 32'h0);
    else
      do_cycle(1'b0, 3'($urandom), rand_addr(), 1'b0, 32'h0, ret, $urandom, $urandom, 1'b0, 32'h0);
  endtask

  task automatic reset_model();
    m_cyc  = 0;
    m_inst = 0;
    pend   = '{v: 1'b0, f3: 3'h0, addr: 32'h0, sc: 0, si: 0};
  endtask

  initial begin
    ld_valid_ex = 0; ld_funct3_ex = 0; ld_addr_ex = 0;
    st_valid_ex = 0; st_addr_ex = 0; inst_retire = 0;
    dmem_rdata = 0; bios_rdata = 0; io_rdata = 0;
    reset_model();
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(ld_valid_mwb), 32'h0);
    check("rst_data", ld_data_mwb, 32'h0);
    check("rst_cycle", cycle_cnt, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed alignment/extension; each constant refers to the previous load.
    do_cycle(1, 3'b000, 32'h1000_0003, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    do_cycle(1, 3'b100, 32'h1000_0003, 0, 0, 0, 32'h80FF_7F01, 32'h0, 1, 32'hFFFF_FF80);
    do_cycle(1, 3'b001, 32'h1000_0002, 0, 0, 0, 32'h80FF_7F01, 32'h0, 1, 32'h0000_0080);
    do_cycle(1, 3'b010, 32'h1000_0000, 0, 0, 0, 32'h80FF_7F01, 32'h0, 1, 32'hFFFF_80FF);
    do_cycle(1, 3'b101, 32'h4000_0000, 0, 0, 0, 32'h80FF_7F01, 32'h0, 1, 32'h80FF_7F01);
    do_cycle(1, 3'b010, 32'h2000_0000, 0, 0, 0, 32'h5555_5555, 32'h1234_ABCD, 1, 32'h0000_ABCD);
    do_cycle(1, 3'b010, 32'h1000_0001, 0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 32'h0);
`ifdef MISALIGN_TRAP_EN
    do_cycle(0, 3'b000, 32'h0, 0, 0, 0, 32'hCAFE_F00D, 32'h0, 1, 32'h0);
`else
    do_cycle(0, 3'b000, 32'h0, 0, 0, 0, 32'hCAFE_F00D, 32'h0, 1, 32'hCAFE_F00D);
`endif

    // 100 cycles, inst_retire high on 60 of them.
    for (int i = 0; i < 100; i++) rand_cycle(i % 5 < 3, 1'b0);

    // Clear counters, read cycle count back-to-back, then instruction count.
    do_cycle(0, 3'b0, 32'h0, 1, RST_A, 0, $urandom, $urandom, 0, 32'h0);
    do_cycle(1, 3'b010, CYC_A, 0, 0, 0, $urandom, $urandom, 0, 32'h0);
    do_cycle(0, 3'b0, 32'h0, 0, 0, 1, $urandom, $urandom, 1, 32'h1);
    do_cycle(0, 3'b0, 32'h0, 0, 0, 0, $urandom, $urandom, 0, 32'h0);
    do_cycle(0, 3'b0, 32'h0, 0, 0, 1, $urandom, $urandom, 0, 32'h0);
    do_cycle(0, 3'b0, 32'h0, 0, 0, 1, $urandom, $urandom, 0, 32'h0);
    do_cycle(0, 3'b0, 32'h0, 0, 0, 0, $urandom, $urandom, 0, 32'h0);
    do_cycle(1, 3'b010, INST_A, 0, 0, 0, $urandom, $urandom, 0, 32'h0);
    do_cycle(0, 3'b0, 32'h0, 0, 0, 0, $urandom, $urandom, 1, 32'h3);

    // Retire and clear in the same cycle.
    do_cycle(0, 3'b0, 32'h0, 1, RST_A, 1, $urandom, $urandom, 0, 32'h0);
    check("inst_clear_wins", inst_cnt, 32'h0);

    // Wrap of the 4-bit instance from all-ones to zero.
    for (int i = 0; i < 20 && (m_cyc % 16) != 15; i++) rand_cycle(1'b1, 1'b0);
    check("small_at_max", s_cycle_cnt, 32'hF);
    rand_cycle(1'b1, 1'b0);
    check("small_wrapped", s_cycle_cnt, 32'h0);

    for (int i = 0; i < 300; i++) rand_cycle(1'($urandom), 1'b1);

    // Asynchronous reset while a load is in MWB.
    do_cycle(1, 3'b010, 32'h1000_0000, 0, 0, 1, $urandom, $urandom, 0, 32'h0);
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check("pre_rst_valid", 32'(ld_valid_mwb), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ld_valid_mwb), 32'h0);
    check("async_rst_data", ld_data_mwb, 32'h0);
    check("async_rst_err", 32'(ld_err_mwb), 32'h0);
    check("async_rst_cycle", cycle_cnt, 32'h0);
    check("async_rst_inst", inst_cnt, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < 50; i++) rand_cycle(1'($urandom), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
